acf_axil_slave_regs: RTL

//  AXI4-Lite slave register bank: the responder end of the bus the ACF host writes through.

---
 rtl/acf_axil_slave_regs.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/acf_axil_slave_regs.sv
// AXI4-Lite slave register bank for the ACF core.
// Write address and write data are captured independently into holding
// registers; a write commits once both are held and no response is pending.
// Reads are single-beat with registered data. The top register index is a
// read-only mirror of the core status word; every lower index is read/write.
module acf_axil_slave_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS           = 8
) (
    input  logic                                   s_axi_aclk,
    input  logic                                   s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH*(NUM_REGS-1)-1:0] regs_out,
    output logic [NUM_REGS-2:0]                    wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int NRW   = NUM_REGS - 1;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Byte-lane merge: lanes with their strobe set take the new data.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                  input logic [DW-1:0] new_word,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_word;
        for (int b = 0; b < SW; b++) begin
            res[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

    logic                  aw_full_r;
    logic [IDX_W-1:0]      aw_idx_r;
    logic                  w_full_r;
    logic [DW-1:0]         w_data_r;
    logic [SW-1:0]         w_strb_r;
    logic                  bvalid_r;
    logic [1:0]            bresp_r;
    logic                  rvalid_r;
    logic [DW-1:0]         rdata_r;
    logic [1:0]            rresp_r;
    logic [DW*NRW-1:0]     regs_r;
    logic [NRW-1:0]        wr_pulse_r;

    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
    logic                  b_done_s;
    logic                  ar_hs_s;
    logic                  r_done_s;
    logic [IDX_W-1:0]      ar_idx_s;
    logic [DW-1:0]         rd_reg_s;
    logic [DW-1:0]         rd_data_s;
    logic [DW*NRW-1:0]     regs_next_s;
    logic [NRW-1:0]        pulse_next_s;
    logic [1:0]            bresp_next_s;
    logic                  unused_s;

    // Protection bits and address bits outside the index field carry no meaning here.
    assign unused_s = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    assign aw_hs_s  = s_axi_awvalid & ~aw_full_r;
    assign w_hs_s   = s_axi_wvalid & ~w_full_r;
    assign commit_s = aw_full_r & w_full_r & ~bvalid_r;
    assign b_done_s = bvalid_r & s_axi_bready;
    assign ar_hs_s  = s_axi_arvalid & ~rvalid_r;
    assign r_done_s = rvalid_r & s_axi_rready;
    assign ar_idx_s = s_axi_araddr[2 +: IDX_W];

    assign s_axi_awready = ~aw_full_r;
    assign s_axi_wready  = ~w_full_r;
    assign s_axi_arready = ~rvalid_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign regs_out      = regs_r;
    assign wr_pulse      = wr_pulse_r;

    // Next register contents and write pulses for a commit to the held index.
    always_comb begin
        regs_next_s  = regs_r;
        pulse_next_s = '0;
        for (int k = 0; k < NRW; k++) begin
            if (commit_s && (aw_idx_r == IDX_W'(k))) begin
                regs_next_s[DW*k +: DW] = merge_bytes(regs_r[DW*k +: DW], w_data_r, w_strb_r);
                pulse_next_s[k]         = |w_strb_r;
            end else begin
                regs_next_s[DW*k +: DW] = regs_r[DW*k +: DW];
                pulse_next_s[k]         = 1'b0;
            end
        end
        bresp_next_s = (aw_idx_r == STATUS_IDX) ? RESP_SLVERR : RESP_OKAY;
    end

    // Read mux: status word at the top index, RW registers below it.
    always_comb begin
        rd_reg_s = '0;
        for (int k = 0; k < NRW; k++) begin
            rd_reg_s = (ar_idx_s == IDX_W'(k)) ? regs_r[DW*k +: DW] : rd_reg_s;
        end
        rd_data_s = (ar_idx_s == STATUS_IDX) ? status_in : rd_reg_s;
    end

    // Write-address holding register: filled on AW handshake, emptied on commit.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_full_r <= 1'b0;
            aw_idx_r  <= '0;
        end else if (commit_s) begin
            aw_full_r <= 1'b0;
        end else if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_idx_r  <= s_axi_awaddr[2 +: IDX_W];
        end else begin
            aw_full_r <= aw_full_r;
        end
    end

    // Write-data holding register: filled on W handshake, emptied on commit.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            w_full_r <= 1'b0;
            w_data_r <= '0;
            w_strb_r <= '0;
        end else if (commit_s) begin
            w_full_r <= 1'b0;
        end else if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= s_axi_wdata;
            w_strb_r <= s_axi_wstrb;
        end else begin
            w_full_r <= w_full_r;
        end
    end

    // Register bank and per-register write pulses.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            regs_r     <= '0;
            wr_pulse_r <= '0;
        end else begin
            regs_r     <= regs_next_s;
            wr_pulse_r <= pulse_next_s;
        end
    end

    // Write response: raised by a commit, held with stable bresp until accepted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (commit_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= bresp_next_s;
        end else if (b_done_s) begin
            bvalid_r <= 1'b0;
        end else begin
            bvalid_r <= bvalid_r;
        end
    end

    // Read response: data captured on AR handshake, held until accepted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rvalid_r <= 1'b0;
            rdata_r  <= '0;
            rresp_r  <= RESP_OKAY;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_data_s;
            rresp_r  <= RESP_OKAY;
        end else if (r_done_s) begin
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rvalid_r;
        end
    end

endmodule
